// File: rtl/sec_pkg.sv
// Shared constants for the burglar-alarm controller: state codes, arm key value and
// the 7-segment font.
package sec_pkg;

  localparam logic [1:0] StDisarmed = 2'd0;
  localparam logic [1:0] StArmed    = 2'd1;
  localparam logic [1:0] StPending  = 2'd2;
  localparam logic [1:0] StAlarm    = 2'd3;

  localparam logic [1:0] KEY_ARM = 2'b11;

  // Segment order a..g in bits 0..6, active-high.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  function automatic logic [6:0] seg_font(input logic [3:0] value);
    case (value)
      4'd0:    seg_font = SEG_0;
      4'd1:    seg_font = SEG_1;
      4'd2:    seg_font = SEG_2;
      4'd3:    seg_font = SEG_3;
      4'd4:    seg_font = SEG_4;
      4'd5:    seg_font = SEG_5;
      4'd6:    seg_font = SEG_6;
      4'd7:    seg_font = SEG_7;
      4'd8:    seg_font = SEG_8;
      4'd9:    seg_font = SEG_9;
      default: seg_font = 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Decimal digit to 7-segment pattern, with a blank override.
module seg7_decode
  import sec_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = blank_i ? 7'h00 : seg_font(value_i);
  end

endmodule

// File: rtl/my_security.sv
// Single-zone alarm controller: key-switch FSM, entry-delay countdown and a
// two-digit multiplexed 7-segment display.
module my_security
  import sec_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned ENTRY_SEC = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] KEY,
  input  logic       DOOR,
  input  logic       WINDOW,
  output logic       ALARM_SIREN,
  output logic       CA,
  output logic [6:0] AN
);

  localparam int unsigned TickW  = $clog2(CLK_FREQ);
  localparam int unsigned RefDiv = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int unsigned RefW   = (RefDiv > 1) ? $clog2(RefDiv) : 1;

  logic [1:0]       state_q, state_d;
  logic [3:0]       sec_q, sec_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [RefW-1:0]  ref_q, ref_d;
  logic             siren_q, siren_d;
  logic             ca_q, ca_d;
  logic [6:0]       an_q, an_d;
  logic             tick, tick_clr, ref_wrap;
  logic [3:0]       disp_val;
  logic             disp_blank;

  assign tick     = (tick_q == TickW'(CLK_FREQ - 1));
  assign ref_wrap = (ref_q == RefW'(RefDiv - 1));

  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    tick_clr = 1'b0;
    if (KEY != KEY_ARM) begin
      state_d = StDisarmed;
      sec_d   = 4'd0;
    end else begin
      case (state_q)
        StDisarmed: state_d = StArmed;
        StArmed: begin
          if (DOOR | WINDOW) begin
            state_d  = StPending;
            sec_d    = 4'(ENTRY_SEC);
            tick_clr = 1'b1;
          end
        end
        StPending: begin
          if (tick) begin
            sec_d = sec_q - 4'd1;
            if (sec_q == 4'd1) state_d = StAlarm;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    tick_d  = (tick_clr || tick) ? '0 : tick_q + TickW'(1);
    ref_d   = ref_wrap ? '0 : ref_q + RefW'(1);
    ca_d    = ref_wrap ? ~ca_q : ca_q;
    siren_d = (state_d == StAlarm);
    // Segments follow next-cycle CA and state so digit select and data change together.
    disp_val   = ca_d ? sec_d : {2'b00, state_d};
    disp_blank = ca_d && (state_d != StPending);
  end

  seg7_decode u_seg7_decode (
    .value_i (disp_val),
    .blank_i (disp_blank),
    .seg_o   (an_d)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StDisarmed;
      sec_q   <= 4'd0;
      tick_q  <= '0;
      ref_q   <= '0;
      siren_q <= 1'b0;
      ca_q    <= 1'b0;
      an_q    <= SEG_0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
      ref_q   <= ref_d;
      siren_q <= siren_d;
      ca_q    <= ca_d;
      an_q    <= an_d;
    end
  end

  assign ALARM_SIREN = siren_q;
  assign CA          = ca_q;
  assign AN          = an_q;

endmodule

// File: tb/tb_my_security.sv
// Bench for my_security at CLK_FREQ=100: a mode/elapsed-time model checked every cycle,
// plus literal expectations on reset, digits and alarm latency.
module tb_my_security;

  localparam int unsigned Freq  = 100;
  localparam int unsigned Entry = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] KEY = 2'b00;
  logic       DOOR = 1'b0;
  logic       WINDOW = 1'b0;
  logic       ALARM_SIREN;
  logic       CA;
  logic [6:0] AN;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  logic [6:0] font [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  my_security #(
    .CLK_FREQ  (Freq),
    .ENTRY_SEC (Entry)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .KEY         (KEY),
    .DOOR        (DOOR),
    .WINDOW      (WINDOW),
    .ALARM_SIREN (ALARM_SIREN),
    .CA          (CA),
    .AN          (AN)
  );

  always #5 CLK = ~CLK;

  // Model: mode 0..3 plus cycles elapsed since the pending-entry edge.
  int   m_mode = 0;
  int   m_elapsed = 0;
  logic m_ca = 1'b0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_mode    <= 0;
      m_elapsed <= 0;
      m_ca      <= 1'b0;
    end else begin
      m_ca <= ~m_ca;  // refresh divider is 1 cycle at this frequency
      if (KEY != 2'b11) m_mode <= 0;
      else if (m_mode == 0) m_mode <= 1;
      else if (m_mode == 1 && (DOOR || WINDOW)) begin
        m_mode    <= 2;
        m_elapsed <= 0;
      end else if (m_mode == 2) begin
        m_elapsed <= m_elapsed + 1;
        if (m_elapsed + 1 == int'(Entry * Freq)) m_mode <= 3;
      end
    end
  end

  function automatic logic [6:0] exp_an();
    int secs;
    if (!m_ca) return font[m_mode];
    if (m_mode != 2) return 7'h00;
    secs = int'(Entry) - m_elapsed / int'(Freq);
    return font[secs];
  endfunction

  always @(negedge CLK) begin
    if (check_en && !RST) begin
      checks = checks + 1;
      if (ALARM_SIREN !== (m_mode == 3) || CA !== m_ca || AN !== exp_an()) begin
        errors = errors + 1;
        $display("FAIL model t=%0t: siren=%b ca=%b an=%h, required siren=%b ca=%b an=%h",
                 $time, ALARM_SIREN, CA, AN, (m_mode == 3), m_ca, exp_an());
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    checks = checks + 1;
    if (got != req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Check the segment pattern on the requested digit (CA toggles every cycle).
  task automatic chk_digit(input string name, input logic want_ca, input logic [6:0] req);
    int n = 0;
    while (CA !== want_ca && n < 3) begin
      cyc(1);
      n++;
    end
    chk({name, "_ca"}, int'(CA), int'(want_ca));
    chk(name, int'(AN), int'(req));
  endtask

  // Pulse a sensor and return the number of edges until the siren rises.
  task automatic measure_alarm(input bit use_window, output int n);
    if (use_window) WINDOW = 1'b1;
    else DOOR = 1'b1;
    cyc(1);
    DOOR = 1'b0;
    WINDOW = 1'b0;
    n = 0;
    while (ALARM_SIREN !== 1'b1 && n <= 400) begin
      cyc(1);
      n++;
      if (CA === 1'b1 && (n == 50 || n == 51)) chk("left_3", int'(AN), 'h4F);
      if (CA === 1'b1 && (n == 150 || n == 151)) chk("left_2", int'(AN), 'h5B);
      if (CA === 1'b1 && (n == 250 || n == 251)) chk("left_1", int'(AN), 'h06);
    end
  endtask

  initial begin
    int n;
    repeat (10) @(posedge CLK);
    #2;
    chk("reset_siren", int'(ALARM_SIREN), 0);
    chk("reset_ca", int'(CA), 0);
    chk("reset_an", int'(AN), 'h3F);
    RST = 1'b0;
    check_en = 1'b1;
    chk_digit("reset_left_blank", 1'b1, 7'h00);

    // Partial key positions and a sensor while disarmed never arm.
    KEY = 2'b01;
    cyc(3);
    DOOR = 1'b1;
    cyc(1);
    DOOR = 1'b0;
    KEY = 2'b10;
    cyc(4);
    chk_digit("key_partial", 1'b0, 7'h3F);

    // Sensor in the arming cycle is ignored.
    KEY = 2'b11;
    DOOR = 1'b1;
    cyc(1);
    DOOR = 1'b0;
    cyc(3);
    chk_digit("armed", 1'b0, 7'h06);
    KEY = 2'b00;
    cyc(2);
    chk_digit("disarmed", 1'b0, 7'h3F);

    // Door intrusion to full alarm.
    KEY = 2'b11;
    cyc(2);
    measure_alarm(1'b0, n);
    chk("door_latency_ok", int'(n >= 299 && n <= 301), 1);
    cyc(3);
    chk_digit("alarm_code", 1'b0, 7'h4F);
    KEY = 2'b00;
    cyc(1);
    chk("disarm_siren", int'(ALARM_SIREN), 0);

    // Window pulse, then abort mid-countdown.
    cyc(2);
    KEY = 2'b11;
    cyc(2);
    WINDOW = 1'b1;
    cyc(1);
    WINDOW = 1'b0;
    chk_digit("pending_code", 1'b0, 7'h5B);
    cyc(147);
    KEY = 2'b00;
    cyc(1);
    chk("abort_siren", int'(ALARM_SIREN), 0);
    cyc(400);
    chk("abort_no_siren", int'(ALARM_SIREN), 0);

    // Re-arm restarts the full delay.
    KEY = 2'b11;
    cyc(2);
    measure_alarm(1'b1, n);
    chk("rearm_latency_ok", int'(n >= 299 && n <= 301), 1);
    cyc(5);

    // Asynchronous reset between edges.
    #1;
    RST = 1'b1;
    #1;
    chk("async_siren", int'(ALARM_SIREN), 0);
    chk("async_ca", int'(CA), 0);
    chk("async_an", int'(AN), 'h3F);
    cyc(2);
    KEY = 2'b00;
    RST = 1'b0;
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
